branch_trap_sequencer: RTL

Program-counter sequencer for the SPARC-style integer pipeline. It consumes the BCOND/TCOND outputs of the condition tester, together with the decoded Bicc/Ticc flags, and maintains PC/nPC with delayed-branch and annul semantics. On a taken Ticc it runs a multi-cycle trap-entry sequence that saves PC/nPC and vectors through TBR. It sits between the decode stage and the instruction-fetch address mux.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_trap_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the PC/nPC branch and trap sequencer.
package branch_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SAVE_PC  = 3'd1,
    ST_SAVE_NPC = 3'd2,
    ST_VECTOR   = 3'd3,
    ST_ERROR    = 3'd4
  } seq_state_e;

  localparam logic [3:0] COND_BA      = 4'b1000;
  localparam logic [3:0] COND_BN      = 4'b0000;
  localparam logic [7:0] TT_TICC_BASE = 8'h80;
  localparam int         ANNUL_BIT    = 4;
  localparam int         COND_MSB     = 3;

  // Branch target relative to the branch's own PC; disp22 counts words.
  function automatic logic [31:0] bicc_target(input logic [31:0] pc,
                                              input logic [21:0] disp22);
    return pc + {{8{disp22[21]}}, disp22, 2'b00};
  endfunction

endpackage

// File: rtl/branch_trap_sequencer.sv
// PC/nPC sequencer with delayed branches, annul handling and Ticc trap entry
// (save PC -> save nPC -> vector through TBR).
module branch_trap_sequencer
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        is_bicc,
  input  logic        is_ticc,
  input  logic [6:0]  IR31_25,
  input  logic [21:0] disp22,
  input  logic        BCOND,
  input  logic        TCOND,
  input  logic [6:0]  trap_num,
  input  logic [19:0] tba,
  input  logic        et,
  output logic [31:0] PC,
  output logic [31:0] nPC,
  output logic        annul,
  output logic        save_we,
  output logic        save_sel,
  output logic [31:0] save_data,
  output logic [7:0]  tt,
  output logic        et_clear,
  output logic        trap_active,
  output logic        error_mode
);

  seq_state_e  state_q;
  logic [31:0] pc_q, npc_q, saved_pc_q, saved_npc_q, save_data_q;
  logic        annul_q, save_we_q, save_sel_q, et_clear_q, trap_active_q, error_mode_q;
  logic [7:0]  tt_q;

  logic [31:0] npc_d, vec_pc;
  logic        annul_d, take_trap;
  logic [3:0]  cond;
  logic        a_bit;

  assign cond   = IR31_25[COND_MSB:0];
  assign a_bit  = IR31_25[ANNUL_BIT];
  assign vec_pc = {tba, tt_q, 4'b0000};

  // Next nPC/annul for a retiring instruction in RUN; PC always becomes nPC.
  always_comb begin
    npc_d     = npc_q + 32'd4;
    annul_d   = 1'b0;
    take_trap = 1'b0;
    if (!annul_q) begin
      if (is_ticc) begin
        take_trap = TCOND;
      end else if (is_bicc) begin
        if (cond == COND_BA) begin
          npc_d   = bicc_target(pc_q, disp22);
          annul_d = a_bit;
        end else if (cond == COND_BN) begin
          annul_d = a_bit;
        end else if (BCOND) begin
          npc_d   = bicc_target(pc_q, disp22);
        end else begin
          annul_d = a_bit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + 32'd4;
      annul_q       <= 1'b0;
      saved_pc_q    <= '0;
      saved_npc_q   <= '0;
      save_we_q     <= 1'b0;
      save_sel_q    <= 1'b0;
      save_data_q   <= '0;
      tt_q          <= '0;
      et_clear_q    <= 1'b0;
      trap_active_q <= 1'b0;
      error_mode_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (advance) begin
            if (take_trap) begin
              tt_q          <= TT_TICC_BASE | {1'b0, trap_num};
              saved_pc_q    <= pc_q;
              saved_npc_q   <= npc_q;
              trap_active_q <= 1'b1;
              if (et) begin
                state_q     <= ST_SAVE_PC;
                save_we_q   <= 1'b1;
                save_sel_q  <= 1'b0;
                save_data_q <= pc_q;
              end else begin
                state_q      <= ST_ERROR;
                error_mode_q <= 1'b1;
              end
            end else begin
              pc_q    <= npc_q;
              npc_q   <= npc_d;
              annul_q <= annul_d;
            end
          end
        end
        ST_SAVE_PC: begin
          state_q     <= ST_SAVE_NPC;
          save_sel_q  <= 1'b1;
          save_data_q <= saved_npc_q;
        end
        ST_SAVE_NPC: begin
          state_q    <= ST_VECTOR;
          save_we_q  <= 1'b0;
          save_sel_q <= 1'b0;
          et_clear_q <= 1'b1;
        end
        ST_VECTOR: begin
          state_q       <= ST_RUN;
          pc_q          <= vec_pc;
          npc_q         <= vec_pc + 32'd4;
          annul_q       <= 1'b0;
          et_clear_q    <= 1'b0;
          trap_active_q <= 1'b0;
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign PC          = pc_q;
  assign nPC         = npc_q;
  assign annul       = annul_q;
  assign save_we     = save_we_q;
  assign save_sel    = save_sel_q;
  assign save_data   = save_data_q;
  assign tt          = tt_q;
  assign et_clear    = et_clear_q;
  assign trap_active = trap_active_q;
  assign error_mode  = error_mode_q;

endmodule
